// File: rtl/sdm_ctrl_pkg.sv
// Shared definitions for the sdm retune sequencer: state encoding and
// modulator timing constants.
package sdm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAMP   = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  localparam int SETTLE_CYC_DEF = 4;
  localparam int SDM_PIPE_DEPTH = 3;

endpackage

// File: rtl/sdm_dwell_cnt.sv
// Clearable up-counter with a terminal-count strobe; used for both the
// per-step dwell timer and the post-ramp settle timer.
module sdm_dwell_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == limit_i);

endmodule

// File: rtl/sdm_ramp_ctrl.sv
// Retune sequencer: walks sdm.din from its current value to a requested target
// in bounded steps with a programmable dwell, then waits for the modulator to settle.
module sdm_ramp_ctrl
  import sdm_ctrl_pkg::*;
#(
  parameter int W          = 16,
  parameter int DWELL_W    = 8,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W-1:0]       tgt_word,
  input  logic [W-1:0]       step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               tgt_valid,
  output logic               tgt_ready,
  input  logic               abort,
  output logic [W-1:0]       sdm_din,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  localparam int SCNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SCNT_W-1:0] SETTLE_LIM = SCNT_W'(SETTLE_CYC - 1);

  if (SETTLE_CYC < SDM_PIPE_DEPTH) begin : g_settle_chk
    $error("SETTLE_CYC must cover the sdm pipeline depth");
  end

  // Distance to target, computed one bit wider so the sign survives.
  function automatic logic [W:0] abs_diff(input logic [W-1:0] cur,
                                          input logic [W-1:0] tgt);
    logic signed [W:0] d;
    d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    return d[W] ? $unsigned(-d) : $unsigned(d);
  endfunction

  // Caller guarantees |tgt-cur| > stp, so the result stays between cur and tgt.
  function automatic logic [W-1:0] step_toward(input logic [W-1:0] cur,
                                               input logic [W-1:0] tgt,
                                               input logic [W-1:0] stp);
    return (tgt > cur) ? (cur + stp) : (cur - stp);
  endfunction

  state_e             state_q, state_d;
  logic [W-1:0]       sdm_din_q, sdm_din_d;
  logic [W-1:0]       tgt_q, step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               tgt_ready_q, tgt_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;
  logic               load;
  logic               dwell_clr, dwell_en, dwell_tc;
  logic               settle_clr, settle_en, settle_tc;
  logic               arrive;

  sdm_dwell_cnt #(.CNT_W(DWELL_W)) u_dwell_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (dwell_clr),
    .en_i    (dwell_en),
    .limit_i (dwell_q),
    .tc_o    (dwell_tc)
  );

  sdm_dwell_cnt #(.CNT_W(SCNT_W)) u_settle_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (settle_clr),
    .en_i    (settle_en),
    .limit_i (SETTLE_LIM),
    .tc_o    (settle_tc)
  );

  assign arrive = (step_q == '0) || (abs_diff(sdm_din_q, tgt_q) <= {1'b0, step_q});

  always_comb begin
    state_d     = state_q;
    sdm_din_d   = sdm_din_q;
    tgt_ready_d = tgt_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    load        = 1'b0;
    dwell_clr   = 1'b0;
    dwell_en    = 1'b0;
    settle_clr  = 1'b0;
    settle_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tgt_ready_d = 1'b1;
        busy_d      = 1'b0;
        if (tgt_valid && tgt_ready_q) begin
          load        = 1'b1;
          dwell_clr   = 1'b1;
          settle_clr  = 1'b1;
          tgt_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = (tgt_word == sdm_din_q) ? ST_SETTLE : ST_RAMP;
        end
      end
      ST_RAMP: begin
        // Abort outranks a coincident update so din freezes where it stands.
        if (abort) begin
          state_d     = ST_IDLE;
          aborted_d   = 1'b1;
          tgt_ready_d = 1'b1;
          busy_d      = 1'b0;
        end else if (dwell_tc) begin
          dwell_clr = 1'b1;
          if (arrive) begin
            sdm_din_d  = tgt_q;
            settle_clr = 1'b1;
            state_d    = ST_SETTLE;
          end else begin
            sdm_din_d = step_toward(sdm_din_q, tgt_q, step_q);
          end
        end else begin
          dwell_en = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d     = ST_IDLE;
          aborted_d   = 1'b1;
          tgt_ready_d = 1'b1;
          busy_d      = 1'b0;
        end else if (settle_tc) begin
          state_d     = ST_IDLE;
          done_d      = 1'b1;
          tgt_ready_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          settle_en = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        tgt_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sdm_din_q   <= '0;
      tgt_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sdm_din_q   <= sdm_din_d;
      tgt_ready_q <= tgt_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  // Request fields are pure data: captured on acceptance, no reset needed.
  always_ff @(posedge clk) begin
    if (load) begin
      tgt_q   <= tgt_word;
      step_q  <= step;
      dwell_q <= dwell;
    end
  end

  assign sdm_din   = sdm_din_q;
  assign tgt_ready = tgt_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_sdm_ramp_ctrl.sv
// Directed bench for sdm_ramp_ctrl: ramps, jump, no-op, abort, hold-off, reset.
module tb_sdm_ramp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] tgt_word;
  logic [15:0] step;
  logic [7:0]  dwell;
  logic        tgt_valid;
  logic        tgt_ready;
  logic        abort;
  logic [15:0] sdm_din;
  logic        busy;
  logic        done;
  logic        aborted;

  int n_cmp = 0;
  int n_err = 0;

  sdm_ramp_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .tgt_word  (tgt_word),
    .step      (step),
    .dwell     (dwell),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .abort     (abort),
    .sdm_din   (sdm_din),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [15:0] t, input logic [15:0] s, input logic [7:0] d);
    tgt_word  = t;
    step      = s;
    dwell     = d;
    tgt_valid = 1'b1;
    tick(1);
    tgt_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tgt_word = '0; step = '0; dwell = '0; tgt_valid = 1'b0; abort = 1'b0;
    tick(2);
    chk("rst_din", sdm_din, 0);
    chk("rst_ready", tgt_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    rst = 1'b0;
    tick(1);

    // Up-ramp 0 -> 1000, step 300, dwell 2
    request(16'd1000, 16'd300, 8'd2);
    chk("up_busy_t", busy, 1);
    chk("up_ready_t", tgt_ready, 0);
    tick(2);  chk("up_t2", sdm_din, 0);
    tick(1);  chk("up_t3", sdm_din, 300);
    tick(3);  chk("up_t6", sdm_din, 600);
    tick(3);  chk("up_t9", sdm_din, 900);
    tick(3);  chk("up_t12", sdm_din, 1000);
    chk("up_done_t12", done, 0);
    tick(3);  chk("up_done_t15", done, 0);
    chk("up_busy_t15", busy, 1);
    tick(1);  chk("up_done_t16", done, 1);
    chk("up_busy_t16", busy, 0);
    chk("up_ready_t16", tgt_ready, 1);
    tick(1);  chk("up_done_t17", done, 0);

    // Down-ramp 1000 -> 100, step 400, dwell 0
    request(16'd100, 16'd400, 8'd0);
    tick(1);  chk("dn_t1", sdm_din, 600);
    tick(1);  chk("dn_t2", sdm_din, 200);
    tick(1);  chk("dn_t3", sdm_din, 100);
    tick(3);  chk("dn_done_t6", done, 0);
    tick(1);  chk("dn_done_t7", done, 1);
    chk("dn_final", sdm_din, 100);

    // Jump 100 -> 0xFFFF with step 0, dwell 1
    request(16'hFFFF, 16'd0, 8'd1);
    tick(1);  chk("jmp_t1", sdm_din, 100);
    tick(1);  chk("jmp_t2", sdm_din, 16'hFFFF);
    tick(3);  chk("jmp_done_t5", done, 0);
    tick(1);  chk("jmp_done_t6", done, 1);

    // No-op: target equals current value
    request(16'hFFFF, 16'd5, 8'd0);
    chk("nop_busy", busy, 1);
    tick(3);  chk("nop_done_t3", done, 0);
    tick(1);  chk("nop_done_t4", done, 1);
    chk("nop_din", sdm_din, 16'hFFFF);

    // Reset mid-ramp: 0xFFFF -> 0, step 1000
    request(16'd0, 16'd1000, 8'd0);
    tick(1);  chk("rr_t1", sdm_din, 16'hFC17);
    rst = 1'b1;
    tick(1);
    chk("rr_din", sdm_din, 0);
    chk("rr_busy", busy, 0);
    chk("rr_ready", tgt_ready, 1);
    chk("rr_done", done, 0);
    chk("rr_aborted", aborted, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("rr_no_done", done, 0);
    end

    // Abort in IDLE is ignored
    abort = 1'b1;
    tick(1);
    chk("idle_abort", aborted, 0);
    chk("idle_abort_ready", tgt_ready, 1);
    abort = 1'b0;

    // Abort coinciding with the 3rd update: 0 -> 1000, step 100, dwell 3
    request(16'd1000, 16'd100, 8'd3);
    tick(4);  chk("ab_t4", sdm_din, 100);
    tick(4);  chk("ab_t8", sdm_din, 200);
    tick(3);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("ab_din_t12", sdm_din, 200);
    chk("ab_pulse", aborted, 1);
    chk("ab_ready", tgt_ready, 1);
    chk("ab_busy", busy, 0);
    tick(1);
    chk("ab_pulse_end", aborted, 0);
    chk("ab_din_t13", sdm_din, 200);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("ab_no_done", done, 0);
    end

    // Hold-off: second request held valid while busy, accepted right after done
    tgt_word = 16'd500; step = 16'd0; dwell = 8'd0; tgt_valid = 1'b1;
    tick(1);
    tgt_word = 16'd800;
    chk("ho_busy_t", busy, 1);
    tick(1);  chk("ho_t1", sdm_din, 500);
    tick(2);  chk("ho_ready_t3", tgt_ready, 0);
    tick(2);  chk("ho_done_t5", done, 1);
    chk("ho_ready_t5", tgt_ready, 1);
    tick(1);
    tgt_valid = 1'b0;
    chk("ho_busy_t6", busy, 1);
    chk("ho_ready_t6", tgt_ready, 0);
    tick(1);  chk("ho_t7", sdm_din, 800);
    tick(3);  chk("ho_done_t10", done, 0);
    tick(1);  chk("ho_done_t11", done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
